// File: rtl/mac_ctrl_pkg.sv
// Shared types and helpers for the MAC sequencing controller.
// Holds the controller state encoding, default geometry and Q8.8 saturation.
// No timing or flow control here; pure declarations.
package mac_ctrl_pkg;

    localparam int VEC_LEN_DEF   = 64;
    localparam int FRAC_BITS_DEF = 8;
    localparam int ACC_W         = 40;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        OUT,
        FIN
    } state_t;

    // Clamp an already-shifted accumulator value into the signed 16-bit range.
    function automatic logic [15:0] sat_q88(input logic signed [ACC_W-1:0] v);
        if (v > 40'sd32767) begin
            return 16'h7FFF;
        end else if (v < -40'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Bundle of start/status, memory read and result handshake signals.
// Combinational wiring only; no latency.
// Results use valid/ready: the controller holds a result until res_ready is seen.
interface mac_seq_ctrl_if #(
    parameter int VEC_LEN = mac_ctrl_pkg::VEC_LEN_DEF
);
    localparam int EW = $clog2(VEC_LEN);
    localparam int NW = EW + 1;

    logic                start;
    logic [NW-1:0]       num_out;
    logic                busy;
    logic                done;
    logic                rd_en;
    logic [EW-1:0]       dmem_addr;
    logic [2*EW-1:0]     wmem_addr;
    logic signed [15:0]  dmem_rdata;
    logic signed [15:0]  wmem_rdata;
    logic                res_valid;
    logic [15:0]         res_data;
    logic [EW-1:0]       res_idx;
    logic                res_ready;

    // Controller side
    modport master (
        input  start, num_out, dmem_rdata, wmem_rdata, res_ready,
        output busy, done, rd_en, dmem_addr, wmem_addr, res_valid, res_data, res_idx
    );

    // Memory / consumer side
    modport slave (
        output start, num_out, dmem_rdata, wmem_rdata, res_ready,
        input  busy, done, rd_en, dmem_addr, wmem_addr, res_valid, res_data, res_idx
    );

endinterface

// File: rtl/mac_lane.sv
// Signed 16x16 multiply feeding a 40-bit signed accumulator.
// One cycle: product of the current operands lands in acc on the next edge.
// No backpressure; clr has priority over en.
module mac_lane
    import mac_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [15:0]      a,
    input  logic signed [15:0]      b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [31:0] prod;

    assign prod = a * b;

    // Accumulator: clear on request, otherwise add sign-extended product when enabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequences VEC_LEN-element dot products for num_out neurons and streams results.
// Latency: start at edge 0 -> reads in cycles 1..VEC_LEN, first result in cycle VEC_LEN+2.
// Backpressure: a result is held in OUT until res_ready; no reads issue while held.
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int VEC_LEN   = VEC_LEN_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mac_seq_ctrl_if.master bus
);

    localparam int              EW        = $clog2(VEC_LEN);
    localparam int              NW        = EW + 1;
    localparam logic [EW-1:0]   ELEM_LAST = EW'(VEC_LEN - 1);
    localparam logic [NW-1:0]   NUM_MAX   = NW'(VEC_LEN);

    state_t                  state;
    state_t                  state_nxt;
    logic [EW-1:0]           elem;
    logic [EW-1:0]           neuron;
    logic [NW-1:0]           num_lat;
    logic [NW-1:0]           num_clamp;
    logic                    rd_en_q;
    logic                    lane_clr;
    logic                    last_neuron;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_shr;

    assign num_clamp   = (bus.num_out > NUM_MAX) ? NUM_MAX : bus.num_out;
    assign last_neuron = ({1'b0, neuron} + NW'(1)) >= num_lat;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the accumulator is cleared whenever a new neuron begins
    always_comb begin
        state_nxt = state;
        lane_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (num_clamp == '0) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = FETCH;
                        lane_clr  = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (elem == ELEM_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = OUT;
            end
            OUT: begin
                if (bus.res_ready) begin
                    if (last_neuron) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = FETCH;
                        lane_clr  = 1'b1;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Element/neuron counters, latched layer size and read-data-valid tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elem    <= '0;
            neuron  <= '0;
            num_lat <= '0;
            rd_en_q <= 1'b0;
        end else begin
            rd_en_q <= (state == FETCH);
            if (state == IDLE && bus.start) begin
                num_lat <= num_clamp;
                neuron  <= '0;
                elem    <= '0;
            end
            if (state == FETCH) begin
                elem <= (elem == ELEM_LAST) ? '0 : elem + EW'(1);
            end
            if (state == OUT && bus.res_ready && !last_neuron) begin
                neuron <= neuron + EW'(1);
            end
        end
    end

    // Read data arrives one cycle after the strobe, so the lane is enabled by the delayed strobe
    mac_lane u_lane (
        .clk   (clk),
        .reset (reset),
        .clr   (lane_clr),
        .en    (rd_en_q),
        .a     (bus.dmem_rdata),
        .b     (bus.wmem_rdata),
        .acc   (acc)
    );

    assign acc_shr = acc >>> FRAC_BITS;

    assign bus.rd_en     = (state == FETCH);
    assign bus.busy      = (state == FETCH) || (state == DRAIN) || (state == OUT);
    assign bus.done      = (state == FIN);
    assign bus.res_valid = (state == OUT);
    assign bus.res_data  = (state == OUT) ? sat_q88(acc_shr) : 16'h0000;
    assign bus.res_idx   = neuron;
    assign bus.dmem_addr = elem;
    assign bus.wmem_addr = {neuron, elem};

endmodule
